// File: rtl/seg7_pkg.sv
// seg7_pkg: seven-segment patterns, decoder and scan states
package seg7_pkg;
  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  typedef enum logic {SCAN_IDLE, SCAN_DIG} scan_state_t;
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0: return SEG_0;
      4'd1: return SEG_1;
      4'd2: return SEG_2;
      4'd3: return SEG_3;
      4'd4: return SEG_4;
      4'd5: return SEG_5;
      4'd6: return SEG_6;
      4'd7: return SEG_7;
      4'd8: return SEG_8;
      4'd9: return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD up/down digit with carry/borrow chaining and saturating load
module bcd_digit (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       up_i,
  input  logic       load_i,
  input  logic       cin_i,
  input  logic [3:0] load_nib_i,
  output logic [3:0] q_o,
  output logic       cout_o
);
  logic [3:0] q_q, q_d;
  logic       at_edge;
  assign at_edge = up_i ? (q_q == 4'd9) : (q_q == 4'd0);
  assign cout_o  = cin_i & at_edge;
  assign q_o     = q_q;
  always_comb
    q_d = load_i ? ((load_nib_i > 4'd9) ? 4'd9 : load_nib_i) :
          !cin_i ? q_q :
          up_i   ? (at_edge ? 4'd0 : q_q + 4'd1) :
                   (at_edge ? 4'd9 : q_q - 4'd1);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) q_q <= 4'd0;
    else         q_q <= q_d;
endmodule

// File: rtl/seg7_mux_counter.sv
// seg7_mux_counter: N-digit BCD up/down counter driving a multiplexed seven-segment display
module seg7_mux_counter import seg7_pkg::*; #(
  parameter int N_DIGITS       = 4,
  parameter int TICK_DIV       = 100_000_000,
  parameter int REFRESH_DIV    = 50_000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit BLANK_LEADING  = 1'b1
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] load_val,
  output logic [4*N_DIGITS-1:0] count,
  output logic                  wrap,
  output logic [6:0]            sevenSeg,
  output logic [N_DIGITS-1:0]   anodes,
  output logic [3:0]            salida
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  logic [TW-1:0]       tick_q, tick_d;
  logic [RW-1:0]       rf_q, rf_d;
  logic [IW-1:0]       idx_q, idx_d;
  scan_state_t         st_q, st_d;
  logic                tick, rtick, wrap_q;
  logic [N_DIGITS:0]   cy;
  logic [N_DIGITS-1:0] shown, oh, an_q;
  logic [6:0]          seg_q, seg_act;
  logic [3:0]          sal_q, nib;
  assign tick   = en && (tick_q == TW'(TICK_DIV - 1));
  assign tick_d = !en ? tick_q : tick ? '0 : tick_q + 1'b1;
  assign rtick  = (rf_q == RW'(REFRESH_DIV - 1));
  assign rf_d   = rtick ? '0 : rf_q + 1'b1;
  // a tick landing on a load cycle is dropped, so the chain never starts then
  assign cy[0]  = tick & ~load;
  for (genvar i = 0; i < N_DIGITS; i++) begin : g_dig
    bcd_digit u_dig (
      .clk_i      (clk_in),
      .rst_ni     (reset),
      .up_i       (up),
      .load_i     (load),
      .cin_i      (cy[i]),
      .load_nib_i (load_val[4*i +: 4]),
      .q_o        (count[4*i +: 4]),
      .cout_o     (cy[i+1])
    );
    assign shown[i] = !BLANK_LEADING || (i == 0) || (count[4*N_DIGITS-1:4*i] != '0);
  end
  always_comb begin
    st_d  = st_q;
    idx_d = idx_q;
    if (rtick) begin
      st_d  = SCAN_DIG;
      idx_d = (st_q == SCAN_IDLE || idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end
  assign nib     = 4'(count >> {idx_d, 2'b00});
  assign oh      = N_DIGITS'(1) << idx_d;
  assign seg_act = shown[idx_d] ? bcd_to_seg(nib) : SEG_BLANK;
  always_ff @(posedge clk_in or negedge reset)
    if (!reset) begin
      tick_q <= '0;
      rf_q   <= '0;
      st_q   <= SCAN_IDLE;
      idx_q  <= '0;
      wrap_q <= 1'b0;
      an_q   <= {N_DIGITS{AN_ACTIVE_LOW}};
      seg_q  <= {7{SEG_ACTIVE_LOW}};
      sal_q  <= 4'd0;
    end else begin
      tick_q <= tick_d;
      rf_q   <= rf_d;
      st_q   <= st_d;
      idx_q  <= idx_d;
      wrap_q <= cy[N_DIGITS];
      if (rtick) begin
        an_q  <= oh ^ {N_DIGITS{AN_ACTIVE_LOW}};
        seg_q <= seg_act ^ {7{SEG_ACTIVE_LOW}};
        sal_q <= nib;
      end
    end
  assign wrap     = wrap_q;
  assign anodes   = an_q;
  assign sevenSeg = seg_q;
  assign salida   = sal_q;
endmodule

// File: tb/tb_seg7_mux_counter.sv
// tb_seg7_mux_counter: random + directed stimulus against a decimal-arithmetic reference model
module tb_seg7_mux_counter;
  logic        clk_in = 1'b0, reset = 1'b1, en = 1'b0, up = 1'b1, load = 1'b0;
  logic [15:0] load_val = '0;
  logic [15:0] count;
  logic        wrap;
  logic [6:0]  sevenSeg;
  logic [3:0]  anodes, salida;
  int checks = 0, failures = 0;
  int p10 [5] = '{1, 10, 100, 1000, 10000};
  logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  int val, pre, rf, idx, wraps;
  bit started, m_wrap;
  logic [3:0] m_an, m_sal;
  logic [6:0] m_seg;

  seg7_mux_counter #(.N_DIGITS(4), .TICK_DIV(4), .REFRESH_DIV(3),
                     .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)) dut (
    .clk_in(clk_in), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count), .wrap(wrap), .sevenSeg(sevenSeg), .anodes(anodes), .salida(salida));

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    for (int k = 0; k < 4; k++) r[4*k +: 4] = 4'((v / p10[k]) % 10);
    return r;
  endfunction

  function automatic int sat_val(input logic [15:0] lv);
    int s = 0;
    for (int k = 0; k < 4; k++) s += ((lv[4*k +: 4] > 4'd9) ? 9 : int'(lv[4*k +: 4])) * p10[k];
    return s;
  endfunction

  task automatic model_reset();
    val = 0; pre = 0; rf = 0; idx = 0; started = 0; m_wrap = 0;
    m_an = 4'hF; m_seg = 7'h7F; m_sal = 4'd0;
  endtask

  task automatic compare_all();
    check("count", count, to_bcd(val));
    check("wrap", wrap, m_wrap);
    check("anodes", anodes, m_an);
    check("seg", sevenSeg, m_seg);
    check("salida", salida, m_sal);
  endtask

  task automatic step();
    int old, d;
    bit tk;
    @(posedge clk_in);
    old = val;
    tk = en && pre == 3;
    if (en) pre = (pre + 1) % 4;
    m_wrap = 0;
    if (load) val = sat_val(load_val);
    else if (tk && up) begin m_wrap = (val == 9999); val = (val + 1) % 10000; end
    else if (tk) begin m_wrap = (val == 0); val = (val + 9999) % 10000; end
    if (rf == 2) begin
      idx = started ? (idx + 1) % 4 : 0;
      started = 1;
      d = (old / p10[idx]) % 10;
      m_an = ~(4'b0001 << idx);
      m_seg = (idx > 0 && old < p10[idx]) ? 7'h7F : ~segtab[d];
      m_sal = 4'(d);
    end
    rf = (rf + 1) % 3;
    @(negedge clk_in);
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk_in);
    @(negedge clk_in);
    reset = 1'b1;
  endtask

  initial begin
    #2;
    do_reset();
    en = 1; up = 1;
    repeat (40) step();
    check("cnt40", count, 16'h0010);
    load_val = 16'h9999; load = 1; step(); load = 0;
    wraps = 0;
    repeat (8) begin step(); if (wrap) wraps++; end
    check("wrap_up_once", wraps, 1);
    check("after_up_wrap", count, 16'h0001);
    load_val = 16'h0000; load = 1; up = 0; step(); load = 0;
    wraps = 0;
    repeat (8) begin step(); if (wrap) wraps++; end
    check("wrap_dn_once", wraps, 1);
    check("after_dn_wrap", count, 16'h9998);
    load_val = 16'h12AF; load = 1; step(); load = 0;
    check("load_sat", count, 16'h1299);
    for (int i = 0; i < 4 && pre != 3; i++) step();
    load_val = 16'h4321; load = 1; step(); load = 0;
    check("load_on_tick", count, 16'h4321);
    en = 0; load_val = 16'h0007; load = 1; step(); load = 0;
    repeat (3) step();
    repeat (12) begin
      step();
      if (anodes == 4'b1110) check("dig0_seven", sevenSeg, 7'b1111000);
      else begin check("lead_blank", sevenSeg, 7'h7F); check("blank_salida", salida, 4'd0); end
    end
    repeat (20) step();
    check("frozen", count, 16'h0007);
    en = 1; up = 1;
    repeat (12) step();
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      up = $urandom_range(0, 1);
      load = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0: load_val = 16'h9999;
        1: load_val = 16'h0000;
        default: load_val = 16'($urandom);
      endcase
      if ($urandom_range(0, 299) == 0) do_reset();
      else step();
    end
    load = 0; en = 1; up = 1;
    repeat (5) step();
    do_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
